ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32IM pipeline.
- Consumes the 176-bit ID/EX bundle and applies operand forwarding.
- Computes ALU, multiply and branch results, plus an iterative 32-cycle divider that stalls upstream stages.
- Registers its results into the 72-bit EX/MEM bundle consumed by the memory stage.

---
 rtl/ex_stage_pkg.sv | 53 +++++
 rtl/ex_stage_div_unit.sv | 71 +++++++
 rtl/ex_stage.sv | 113 +++++++++++
 tb/tb_ex_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared encodings and bundle layouts for the RV32IM execute stage.
package ex_stage_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

    localparam int EC_SRC_B_IMM = 4;
    localparam int EC_SRC_A_PC  = 5;
    localparam int EC_BRANCH    = 6;
    localparam int EC_JAL       = 7;
    localparam int EC_JALR      = 8;
    localparam int EC_M_EXT     = 9;

    localparam int ID_EX_W   = 176;
    localparam int EX_MEM_W  = 72;
    localparam int EX_CON_W  = 13;
    localparam int IX_REG    = 175;
    localparam int IX_MEM    = 173;
    localparam int IX_EX_CON = 160;
    localparam int IX_PC     = 128;
    localparam int IX_DATA1  = 96;
    localparam int IX_DATA2  = 64;
    localparam int IX_IMM    = 32;
    localparam int IX_INSTR  = 0;

    localparam int EM_REG    = 71;
    localparam int EM_MEM    = 69;
    localparam int EM_RESULT = 37;
    localparam int EM_STORE  = 5;
    localparam int EM_RD     = 0;

    localparam logic [1:0] FWD_DATA = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;
    localparam logic [2:0] F3_BLT    = 3'b100;
    localparam logic [2:0] F3_BGE    = 3'b101;
    localparam logic [2:0] F3_BLTU   = 3'b110;
    localparam logic [2:0] F3_BGEU   = 3'b111;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;
endpackage

// File: rtl/ex_stage_div_unit.sv
// div_unit: iterative restoring divider on operand magnitudes with sign fix-up;
// op[0]=unsigned, op[1]=remainder.
module div_unit
    import ex_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    div_state_e      state;
    logic [4:0]      cnt;
    logic [XLEN-1:0] rem, quo, dvs;
    logic            neg_q, neg_r, div_zero, want_rem;
    logic            sa, sb;
    logic [XLEN:0]   shifted, trial;

    assign sa      = !op[0] && a[XLEN-1];
    assign sb      = !op[0] && b[XLEN-1];
    assign shifted = {rem, quo[XLEN-1]};
    assign trial   = shifted - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= DIV_IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            want_rem <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: if (start) begin
                    state    <= DIV_RUN;
                    cnt      <= '0;
                    rem      <= '0;
                    quo      <= sa ? -a : a;
                    dvs      <= sb ? -b : b;
                    neg_q    <= sa ^ sb;
                    neg_r    <= sa;
                    div_zero <= (b == '0);
                    want_rem <= op[1];
                end
                DIV_RUN: begin
                    rem   <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
                    quo   <= {quo[XLEN-2:0], ~trial[XLEN]};
                    cnt   <= cnt + 5'd1;
                    state <= (cnt == 5'(DIV_CYCLES - 1)) ? DIV_DONE : DIV_RUN;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    // A zero divisor leaves the dividend magnitude in rem, so only the quotient needs overriding.
    assign result = want_rem ? (neg_r ? -rem : rem)
                             : (div_zero ? '1 : (neg_q ? -quo : quo));
    assign busy   = rst && (state == DIV_RUN || (state == DIV_IDLE && start));
    assign done   = state == DIV_DONE;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32IM execute stage -- forwarding, ALU, multiplier, branch resolution
// and a stalling iterative divider, registered into the EX/MEM bundle.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_EX_W-1:0]  ID_EX,
    input  logic [1:0]          fwd_a_sel,
    input  logic [1:0]          fwd_b_sel,
    input  logic [XLEN-1:0]     mem_fwd_data,
    input  logic [XLEN-1:0]     wb_fwd_data,
    output logic [EX_MEM_W-1:0] EX_MEM,
    output logic                branch_taken,
    output logic [XLEN-1:0]     branch_target,
    output logic                stall
);
    logic                reg_con, valid, div_op, div_done, take, cond, unused_bits;
    logic [1:0]          mem_con;
    logic [EX_CON_W-1:0] ex_con;
    logic [XLEN-1:0]     pc, data1, data2, imm, instr;
    logic [XLEN-1:0]     a_fwd, b_fwd, op_a, op_b, alu, mul, div_result, result, target;
    logic [63:0]         ext_a, ext_b, prod;
    logic [2:0]          funct3;
    alu_op_e             alu_op;

    assign reg_con = ID_EX[IX_REG];
    assign mem_con = ID_EX[IX_MEM +: 2];
    assign ex_con  = ID_EX[IX_EX_CON +: EX_CON_W];
    assign pc      = ID_EX[IX_PC +: XLEN];
    assign data1   = ID_EX[IX_DATA1 +: XLEN];
    assign data2   = ID_EX[IX_DATA2 +: XLEN];
    assign imm     = ID_EX[IX_IMM +: XLEN];
    assign instr   = ID_EX[IX_INSTR +: XLEN];
    assign funct3  = instr[14:12];
    assign alu_op  = alu_op_e'(ex_con[3:0]);
    assign valid   = instr != '0;
    assign unused_bits = ^{ex_con[12:10], instr[31:15], instr[6:0]};

    assign a_fwd = fwd_a_sel == FWD_MEM ? mem_fwd_data : fwd_a_sel == FWD_WB ? wb_fwd_data : data1;
    assign b_fwd = fwd_b_sel == FWD_MEM ? mem_fwd_data : fwd_b_sel == FWD_WB ? wb_fwd_data : data2;
    assign op_a  = ex_con[EC_SRC_A_PC] ? pc : a_fwd;
    assign op_b  = ex_con[EC_SRC_B_IMM] ? imm : b_fwd;

    always_comb begin
        case (alu_op)
            ALU_ADD:    alu = op_a + op_b;
            ALU_SUB:    alu = op_a - op_b;
            ALU_SLL:    alu = op_a << op_b[4:0];
            ALU_SLT:    alu = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu = {31'd0, op_a < op_b};
            ALU_XOR:    alu = op_a ^ op_b;
            ALU_SRL:    alu = op_a >> op_b[4:0];
            ALU_SRA:    alu = $signed(op_a) >>> op_b[4:0];
            ALU_OR:     alu = op_a | op_b;
            ALU_AND:    alu = op_a & op_b;
            ALU_PASS_B: alu = op_b;
            default:    alu = '0;
        endcase
    end

    // Sign-extending to 64 bits makes a plain low-64 product correct for every signedness mix.
    assign ext_a = {{32{(funct3 == F3_MULH || funct3 == F3_MULHSU) && op_a[31]}}, op_a};
    assign ext_b = {{32{funct3 == F3_MULH && op_b[31]}}, op_b};
    assign prod  = ext_a * ext_b;
    assign mul   = funct3 == F3_MUL ? prod[31:0] : prod[63:32];

    always_comb begin
        case (funct3)
            F3_BEQ:  cond = a_fwd == b_fwd;
            F3_BNE:  cond = a_fwd != b_fwd;
            F3_BLT:  cond = $signed(a_fwd) < $signed(b_fwd);
            F3_BGE:  cond = $signed(a_fwd) >= $signed(b_fwd);
            F3_BLTU: cond = a_fwd < b_fwd;
            F3_BGEU: cond = a_fwd >= b_fwd;
            default: cond = 1'b0;
        endcase
    end

    assign take   = valid && (ex_con[EC_JAL] || ex_con[EC_JALR] || (ex_con[EC_BRANCH] && cond));
    assign target = ex_con[EC_JALR] ? ((a_fwd + imm) & ~32'd1) : pc + imm;
    assign div_op = valid && ex_con[EC_M_EXT] && funct3[2];
    assign result = (ex_con[EC_JAL] || ex_con[EC_JALR]) ? pc + 32'd4 :
                    !ex_con[EC_M_EXT] ? alu : funct3[2] ? div_result : mul;

    div_unit #(.XLEN(XLEN), .DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk    (clk),
        .rst    (rst),
        .start  (div_op),
        .op     (funct3[1:0]),
        .a      (a_fwd),
        .b      (b_fwd),
        .busy   (stall),
        .done   (div_done),
        .result (div_result)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            EX_MEM        <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else begin
            EX_MEM        <= (!stall && valid && (!div_op || div_done))
                             ? {reg_con, mem_con, result, b_fwd, instr[11:7]} : '0;
            branch_taken  <= take;
            branch_target <= target;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scoreboard bench for ex_stage.
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam logic [5:0] F_IMM = 6'b000001, F_PC = 6'b000010, F_BR = 6'b000100,
                           F_JAL = 6'b001000, F_JALR = 6'b010000, F_M = 6'b100000;

    typedef struct {
        string       tag;
        logic [71:0] v;
    } exp_t;

    logic         clk = 1'b0, rst = 1'b0;
    logic [175:0] id_ex = '0;
    logic [1:0]   fwd_a_sel = 2'b00, fwd_b_sel = 2'b00;
    logic [31:0]  mem_fwd_data = '0, wb_fwd_data = '0;
    logic [71:0]  ex_mem;
    logic         branch_taken, stall;
    logic [31:0]  branch_target;
    exp_t         sb[$];
    int           n_cmp = 0, n_err = 0;

    ex_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ID_EX         (id_ex),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel),
        .mem_fwd_data  (mem_fwd_data),
        .wb_fwd_data   (wb_fwd_data),
        .EX_MEM        (ex_mem),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [12:0] ecf(input logic [3:0] op, input logic [5:0] flags);
        return {3'b000, flags, op};
    endfunction

    function automatic logic [175:0] idex(input logic rc, input logic [1:0] mc, input logic [12:0] ec,
                                          input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                                          input logic [31:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {rc, mc, ec, pc, d1, d2, imm, 17'd0, f3, rd, 7'h33};
    endfunction

    function automatic logic [71:0] em(input logic rc, input logic [1:0] mc, input logic [31:0] res,
                                       input logic [31:0] sd, input logic [4:0] rd);
        return {rc, mc, res, sd, rd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 72'(sb.size()), 72'd1);
        end else begin
            e = sb.pop_front();
            chk(e.tag, ex_mem, e.v);
        end
    endtask

    task automatic issue(input string tag, input logic [175:0] v, input logic [71:0] e);
        id_ex = v;
        sb.push_back('{tag, e});
        #1;
        chk({tag, "_stall"}, {71'd0, stall}, 72'd0);
        tick();
        pop_chk();
    endtask

    task automatic run_div(input string tag, input logic [175:0] v, input logic [71:0] e);
        int n = 0;
        logic bad = 1'b0;
        id_ex = v;
        sb.push_back('{tag, e});
        #1;
        chk({tag, "_stall_start"}, {71'd0, stall}, 72'd1);
        while (stall && n < 100) begin
            n++;
            tick();
            if (ex_mem !== '0) bad = 1'b1;
        end
        chk({tag, "_stall_cycles"}, 72'(n), 72'd33);
        chk({tag, "_bubble"}, {71'd0, bad}, 72'd0);
        tick();
        pop_chk();
        id_ex = '0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_ex_mem", ex_mem, 72'd0);
        chk("rst_branch", {71'd0, branch_taken}, 72'd0);
        chk("rst_target", {40'd0, branch_target}, 72'd0);
        chk("rst_stall", {71'd0, stall}, 72'd0);
        rst = 1'b1;

        issue("add", idex(1, 0, ecf(ALU_ADD, 0), 0, 5, 7, 0, 0, 3), em(1, 0, 12, 7, 3));
        fwd_a_sel = FWD_MEM; mem_fwd_data = 100;
        issue("fwd_a_sub", idex(1, 0, ecf(ALU_SUB, 0), 0, 1, 30, 0, 0, 4), em(1, 0, 70, 30, 4));
        fwd_a_sel = FWD_DATA; fwd_b_sel = FWD_WB; wb_fwd_data = 32'h55;
        issue("fwd_b_add", idex(1, 0, ecf(ALU_ADD, 0), 0, 1, 1, 0, 0, 5), em(1, 0, 32'h56, 32'h55, 5));
        fwd_b_sel = 2'b11;
        issue("fwd_rsvd", idex(1, 0, ecf(ALU_ADD, 0), 0, 1, 2, 0, 0, 5), em(1, 0, 3, 2, 5));
        fwd_b_sel = FWD_DATA;
        issue("addi", idex(0, 2, ecf(ALU_ADD, F_IMM), 0, 10, 32'h99, 32'hFFFFFFFD, 0, 0), em(0, 2, 7, 32'h99, 0));
        issue("sra", idex(1, 0, ecf(ALU_SRA, 0), 0, 32'h80000010, 4, 0, 0, 6), em(1, 0, 32'hF8000001, 4, 6));
        issue("srl", idex(1, 0, ecf(ALU_SRL, 0), 0, 32'h80000010, 4, 0, 0, 6), em(1, 0, 32'h08000001, 4, 6));
        issue("sll", idex(1, 0, ecf(ALU_SLL, 0), 0, 1, 32'h3F, 0, 0, 7), em(1, 0, 32'h80000000, 32'h3F, 7));
        issue("slt", idex(1, 0, ecf(ALU_SLT, 0), 0, 32'hFFFFFFFF, 1, 0, 0, 8), em(1, 0, 1, 1, 8));
        issue("sltu", idex(1, 0, ecf(ALU_SLTU, 0), 0, 32'hFFFFFFFF, 1, 0, 0, 8), em(1, 0, 0, 1, 8));
        issue("xor", idex(1, 0, ecf(ALU_XOR, 0), 0, 32'hF0F0, 32'hFF00, 0, 0, 9), em(1, 0, 32'h0FF0, 32'hFF00, 9));
        issue("lui", idex(1, 0, ecf(ALU_PASS_B, F_IMM), 0, 3, 4, 32'h12345000, 0, 9), em(1, 0, 32'h12345000, 4, 9));
        issue("auipc", idex(1, 0, ecf(ALU_ADD, F_IMM | F_PC), 32'h1000, 3, 4, 32'h2000, 0, 9), em(1, 0, 32'h3000, 4, 9));
        issue("mul", idex(1, 0, ecf(0, F_M), 0, 32'hFFFFFFFF, 2, 0, F3_MUL, 10), em(1, 0, 32'hFFFFFFFE, 2, 10));
        issue("mulh", idex(1, 0, ecf(0, F_M), 0, 32'hFFFFFFFF, 2, 0, F3_MULH, 10), em(1, 0, 32'hFFFFFFFF, 2, 10));
        issue("mulhsu", idex(1, 0, ecf(0, F_M), 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, F3_MULHSU, 10),
              em(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 10));
        issue("mulhu", idex(1, 0, ecf(0, F_M), 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, F3_MULHU, 10),
              em(1, 0, 32'hFFFFFFFE, 32'hFFFFFFFF, 10));

        issue("beq", idex(0, 0, ecf(ALU_SUB, F_BR), 32'h40, 9, 9, 32'h10, F3_BEQ, 0), em(0, 0, 0, 9, 0));
        chk("beq_taken", {71'd0, branch_taken}, 72'd1);
        chk("beq_target", {40'd0, branch_target}, 72'h50);
        issue("bubble", '0, 72'd0);
        chk("beq_one_cycle", {71'd0, branch_taken}, 72'd0);
        issue("bne", idex(0, 0, ecf(ALU_SUB, F_BR), 32'h40, 9, 9, 32'h10, F3_BNE, 0), em(0, 0, 0, 9, 0));
        chk("bne_not_taken", {71'd0, branch_taken}, 72'd0);
        issue("blt", idex(0, 0, ecf(ALU_SUB, F_BR), 32'h80, 32'hFFFFFFFF, 1, 32'hFFFFFFF0, F3_BLT, 0),
              em(0, 0, 32'hFFFFFFFE, 1, 0));
        chk("blt_taken", {71'd0, branch_taken}, 72'd1);
        chk("blt_target", {40'd0, branch_target}, 72'h70);
        issue("bltu", idex(0, 0, ecf(ALU_SUB, F_BR), 32'h80, 32'hFFFFFFFF, 1, 32'h8, F3_BLTU, 0),
              em(0, 0, 32'hFFFFFFFE, 1, 0));
        chk("bltu_not_taken", {71'd0, branch_taken}, 72'd0);
        issue("jal", idex(1, 0, ecf(ALU_ADD, F_JAL), 32'h100, 0, 0, 32'h20, 0, 1), em(1, 0, 32'h104, 0, 1));
        chk("jal_taken", {71'd0, branch_taken}, 72'd1);
        chk("jal_target", {40'd0, branch_target}, 72'h120);
        issue("jalr", idex(1, 0, ecf(ALU_ADD, F_JALR), 32'h300, 32'h201, 0, 4, 0, 1), em(1, 0, 32'h304, 0, 1));
        chk("jalr_taken", {71'd0, branch_taken}, 72'd1);
        chk("jalr_target", {40'd0, branch_target}, 72'h204);
        id_ex = {1'b1, 2'b11, ecf(0, F_M), 128'hFFFF, 32'd0};
        #1;
        chk("bubble_no_div", {71'd0, stall}, 72'd0);
        tick();
        chk("bubble_ctl", {69'd0, ex_mem[71:69]}, 72'd0);
        chk("jalr_one_cycle", {71'd0, branch_taken}, 72'd0);

        run_div("div", idex(1, 0, ecf(0, F_M), 0, 32'hFFFFFFF9, 2, 0, F3_DIV, 5), em(1, 0, 32'hFFFFFFFD, 2, 5));
        run_div("rem", idex(1, 0, ecf(0, F_M), 0, 32'hFFFFFFF9, 2, 0, F3_REM, 6), em(1, 0, 32'hFFFFFFFF, 2, 6));
        run_div("divu0", idex(1, 0, ecf(0, F_M), 0, 10, 0, 0, F3_DIVU, 7), em(1, 0, 32'hFFFFFFFF, 0, 7));
        run_div("remu0", idex(1, 0, ecf(0, F_M), 0, 10, 0, 0, F3_REMU, 7), em(1, 0, 10, 0, 7));
        run_div("div_ovf", idex(1, 0, ecf(0, F_M), 0, 32'h80000000, 32'hFFFFFFFF, 0, F3_DIV, 8),
                em(1, 0, 32'h80000000, 32'hFFFFFFFF, 8));
        run_div("rem_ovf", idex(1, 0, ecf(0, F_M), 0, 32'h80000000, 32'hFFFFFFFF, 0, F3_REM, 8),
                em(1, 0, 0, 32'hFFFFFFFF, 8));

        id_ex = idex(1, 0, ecf(0, F_M), 0, 32'hFFFFFFF9, 2, 0, F3_DIV, 5);
        repeat (10) tick();
        chk("mid_div_stall", {71'd0, stall}, 72'd1);
        rst = 1'b0;
        tick();
        chk("rst_mid_ex_mem", ex_mem, 72'd0);
        chk("rst_mid_stall", {71'd0, stall}, 72'd0);
        rst = 1'b1;
        issue("add_after_rst", idex(1, 0, ecf(ALU_ADD, 0), 0, 2, 3, 0, 0, 2), em(1, 0, 5, 3, 2));
        run_div("divu", idex(1, 0, ecf(0, F_M), 0, 100, 7, 0, F3_DIVU, 9), em(1, 0, 14, 7, 9));

        chk("sb_empty", 72'(sb.size()), 72'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
